mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-master arbiter in front of one single-port memory. An instruction fetch
//   port and a data port compete for the memory. Data normally wins. A streak
//   counter stops data from starving a fetch that is waiting. A timeout
//   counter ends a transfer the memory never acknowledges.
//
//   Parameters
//     STARVE_MAX : max consecutive data grants made while a fetch is waiting
//     TIMEOUT    : max BUSY cycles without m_ack_i (8-bit counter)
//
//   Ports
//     clk, rst                          : rising-edge clock, sync active-high reset
//     if_req_i, if_addr_i               : fetch request / word address
//     if_data_o, if_ack_o               : fetch read data / one-cycle completion
//     d_req_i, d_we_i, d_sel_i,
//     d_addr_i, d_wdata_i               : data request, write enable, byte selects,
//                                         address, write data
//     d_rdata_o, d_ack_o                : data read data / one-cycle completion
//     m_ce_o, m_we_o, m_sel_o,
//     m_addr_o, m_wdata_o               : memory command (registered)
//     m_rdata_i, m_ack_i                : memory read data / completion
//     err_o                             : one-cycle pulse when a transfer times out
//     stall_o                           : pipeline stall while any request is pending
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_data_o,
   output logic        if_ack_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_sel_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_wdata_i,
   output logic [31:0] d_rdata_o,
   output logic        d_ack_o,
   output logic        m_ce_o,
   output logic        m_we_o,
   output logic [3:0]  m_sel_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_wdata_o,
   input  logic [31:0] m_rdata_i,
   input  logic        m_ack_i,
   output logic        err_o,
   output logic        stall_o
);

   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t        state;
   logic [SW-1:0] streak;
   logic [7:0]    tmo_cnt;
   logic          fetch_wins;
   logic          tmo_hit;

   // Fetch wins when data is idle, or when data has already had its
   // STARVE_MAX consecutive grants while the fetch was waiting.
   always_comb begin
      fetch_wins = if_req_i & (~d_req_i | (streak == SW'(STARVE_MAX)));
      tmo_hit    = (tmo_cnt == 8'(TIMEOUT - 1));
   end

   always_comb begin
      stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         tmo_cnt   <= '0;
         m_ce_o    <= 1'b0;
         m_we_o    <= 1'b0;
         m_sel_o   <= '0;
         m_addr_o  <= '0;
         m_wdata_o <= '0;
         if_data_o <= '0;
         if_ack_o  <= 1'b0;
         d_rdata_o <= '0;
         d_ack_o   <= 1'b0;
         err_o     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_wins) begin
                  state     <= BUSY_I;
                  m_ce_o    <= 1'b1;
                  m_we_o    <= 1'b0;
                  m_sel_o   <= 4'hF;
                  m_addr_o  <= if_addr_i;
                  m_wdata_o <= '0;
                  tmo_cnt   <= '0;
                  streak    <= '0;
               end else if (d_req_i) begin
                  state     <= BUSY_D;
                  m_ce_o    <= 1'b1;
                  m_we_o    <= d_we_i;
                  m_sel_o   <= d_sel_i;
                  m_addr_o  <= d_addr_i;
                  m_wdata_o <= d_wdata_i;
                  tmo_cnt   <= '0;
                  streak    <= if_req_i ? streak + SW'(1) : '0;
               end else begin
                  streak    <= '0;
               end
            end

            BUSY_I, BUSY_D: begin
               // Acknowledge and timeout share one completion path. A timeout
               // returns zero data and raises err_o alongside the ack.
               if (m_ack_i || tmo_hit) begin
                  state  <= DONE;
                  m_ce_o <= 1'b0;
                  err_o  <= ~m_ack_i;
                  if (state == BUSY_I) begin
                     if_data_o <= m_ack_i ? m_rdata_i : '0;
                     if_ack_o  <= 1'b1;
                  end else begin
                     d_rdata_o <= m_ack_i ? m_rdata_i : '0;
                     d_ack_o   <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end

            DONE: begin
               state    <= IDLE;
               if_ack_o <= 1'b0;
               d_ack_o  <= 1'b0;
               err_o    <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A transaction-level reference model
//   predicts every output each cycle. Directed scenarios add literal
//   expectations on top of that prediction.
module tb_mem_arbiter;
   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 255;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_ack_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [3:0]  d_sel_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_ack_o;
   logic        m_ce_o;
   logic        m_we_o;
   logic [3:0]  m_sel_o;
   logic [31:0] m_addr_o;
   logic [31:0] m_wdata_o;
   logic [31:0] m_rdata_i;
   logic        m_ack_i;
   logic        err_o;
   logic        stall_o;

   logic        resp_ack   = 1'b0;
   logic [31:0] resp_data  = '1;
   logic        force_ack  = 1'b0;
   logic [31:0] force_data = '0;
   assign m_ack_i   = resp_ack | force_ack;
   assign m_rdata_i = force_ack ? force_data : resp_data;

   mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_data_o(if_data_o), .if_ack_o(if_ack_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
      .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
      .m_ce_o(m_ce_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
      .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
      .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i),
      .err_o(err_o), .stall_o(stall_o)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Memory responder: acks mem_lat cycles after m_ce_o first appears.
   // mem_lat < 0 means the memory never answers.
   int mem_lat = 1;
   int ce_cnt  = 0;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h100) ? 32'h3C01_0001 : (a ^ 32'h5A5A_0000);
   endfunction
   initial begin
      forever begin
         @(posedge clk); #1;
         ce_cnt = (m_ce_o === 1'b1) ? ce_cnt + 1 : 0;
         if (mem_lat >= 0 && ce_cnt == mem_lat + 1) begin
            resp_ack  = 1'b1;
            resp_data = mem_word(m_addr_o);
         end else begin
            resp_ack  = 1'b0;
            resp_data = 32'hFFFF_FFFF;
         end
      end
   end

   // Reference model. It tracks who owns the memory, whether a completion is
   // being shown, how long the owner has waited, and how many data grants
   // were given while a fetch was waiting.
   int          owner = 0;       // 0 none, 1 fetch, 2 data
   bit          showing = 0;
   int          waited = 0;
   int          data_while_fetch = 0;
   bit          model_ok = 0;
   bit          fetch_turn;
   logic        e_ce, e_we, e_if_ack, e_d_ack, e_err;
   logic [3:0]  e_sel;
   logic [31:0] e_addr, e_wdata, e_if_data, e_d_data;

   always @(posedge clk) begin
      if (rst) begin
         owner = 0; showing = 0; waited = 0; data_while_fetch = 0;
         e_ce = 0; e_we = 0; e_sel = 0; e_addr = 0; e_wdata = 0;
         e_if_ack = 0; e_d_ack = 0; e_err = 0; e_if_data = 0; e_d_data = 0;
         model_ok = 1;
      end else if (showing) begin
         showing = 0; e_if_ack = 0; e_d_ack = 0; e_err = 0;
      end else if (owner != 0) begin
         waited++;
         if (m_ack_i || waited == TIMEOUT) begin
            if (owner == 1) begin
               e_if_data = m_ack_i ? m_rdata_i : 32'h0; e_if_ack = 1;
            end else begin
               e_d_data = m_ack_i ? m_rdata_i : 32'h0; e_d_ack = 1;
            end
            e_err = !m_ack_i; e_ce = 0; owner = 0; showing = 1;
         end
      end else begin
         fetch_turn = if_req_i && (!d_req_i || data_while_fetch >= STARVE_MAX);
         if (fetch_turn) begin
            owner = 1; e_ce = 1; e_we = 0; e_sel = 4'hF;
            e_addr = if_addr_i; e_wdata = 0; waited = 0; data_while_fetch = 0;
         end else if (d_req_i) begin
            owner = 2; e_ce = 1; e_we = d_we_i; e_sel = d_sel_i;
            e_addr = d_addr_i; e_wdata = d_wdata_i; waited = 0;
            data_while_fetch = if_req_i ? data_while_fetch + 1 : 0;
         end else begin
            data_while_fetch = 0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (model_ok) begin
         chk("m_ce",  m_ce_o,  e_ce);
         chk("m_we",  m_we_o,  e_we);
         chk("m_sel", m_sel_o, e_sel);
         chk("m_addr", m_addr_o, e_addr);
         chk("m_wdata", m_wdata_o, e_wdata);
         chk("if_ack", if_ack_o, e_if_ack);
         chk("d_ack",  d_ack_o,  e_d_ack);
         chk("err",    err_o,    e_err);
         chk("if_data", if_data_o, e_if_data);
         chk("d_rdata", d_rdata_o, e_d_data);
         chk("stall", stall_o, (if_req_i & ~e_if_ack) | (d_req_i & ~e_d_ack));
      end
   end

   // Grant / event monitor used by the directed checks.
   logic        prev_ce = 1'b0;
   int          n_grants = 0;
   logic [31:0] g_code = '0;
   logic [31:0] g0_addr, g0_wdata;
   logic        g0_we;
   logic [3:0]  g0_sel;
   int          err_cnt = 0;
   int          dack_cnt = 0;
   int          ce_run = 0;
   always @(negedge clk) begin
      if (m_ce_o === 1'b1 && prev_ce !== 1'b1) begin
         if (n_grants == 0) begin
            g0_addr = m_addr_o; g0_wdata = m_wdata_o; g0_we = m_we_o; g0_sel = m_sel_o;
         end
         n_grants++;
         g_code = (g_code << 4) | ((m_addr_o[13] | m_addr_o[10] | m_addr_o[9]) ? 32'hD : 32'hF);
      end
      prev_ce = m_ce_o;
      if (err_o === 1'b1)   err_cnt++;
      if (d_ack_o === 1'b1) dack_cnt++;
      if (m_ce_o === 1'b1)  ce_run++;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_ack(input bit data_side, input int max_cyc, output int cyc);
      bit seen;
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < max_cyc) begin
         @(negedge clk);
         cyc++;
         seen = data_side ? (d_ack_o === 1'b1) : (if_ack_o === 1'b1);
      end
      #1;
      chk(data_side ? "d_ack_arrives" : "if_ack_arrives", seen, 1);
   endtask

   int cyc, e0, c0, d0;
   bit da, fa;

   initial begin
      rst = 1; if_req_i = 0; if_addr_i = 0; d_req_i = 0; d_we_i = 0;
      d_sel_i = 0; d_addr_i = 0; d_wdata_i = 0;
      repeat (3) step();
      rst = 0;
      @(negedge clk); #1;
      chk("rst_ce", m_ce_o, 0);
      chk("rst_sel", m_sel_o, 0);
      chk("rst_addr", m_addr_o, 0);
      chk("rst_data", d_rdata_o, 0);

      // Fetch only.
      step();
      if_req_i = 1; if_addr_i = 32'h100;
      wait_ack(0, 20, cyc);
      chk("fetch_latency", cyc, 4);
      chk("fetch_addr", m_addr_o, 32'h100);
      chk("fetch_data", if_data_o, 32'h3C01_0001);
      step(); if_req_i = 0;
      @(negedge clk); #1;
      chk("fetch_ack_one_pulse", if_ack_o, 0);
      chk("fetch_data_held", if_data_o, 32'h3C01_0001);

      // Simultaneous requests: data first, then fetch.
      step();
      n_grants = 0; g_code = 0;
      if_req_i = 1; if_addr_i = 32'h180;
      d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF; d_sel_i = 4'hF;
      wait_ack(1, 20, cyc);
      chk("both_first_we", g0_we, 1);
      chk("both_first_addr", g0_addr, 32'h200);
      chk("both_first_wdata", g0_wdata, 32'hDEAD_BEEF);
      chk("both_first_sel", g0_sel, 4'hF);
      step(); d_req_i = 0; d_we_i = 0;
      wait_ack(0, 20, cyc);
      step(); if_req_i = 0;
      chk("both_order", g_code, 32'hDF);

      // Starvation limit: both held, data re-requests after every ack.
      step();
      n_grants = 0; g_code = 0;
      if_req_i = 1; if_addr_i = 32'h1000;
      d_req_i = 1; d_we_i = 1; d_addr_i = 32'h2000; d_wdata_i = 32'h1111_0000; d_sel_i = 4'h3;
      for (int c = 0; c < 200 && n_grants < 10; c++) begin
         @(negedge clk); #1;
         da = d_ack_o; fa = if_ack_o;
         step();
         if (da) begin d_addr_i += 4; d_wdata_i += 1; end
         if (fa) if_addr_i += 4;
      end
      d_req_i = 0; d_we_i = 0;
      wait_ack(0, 20, cyc);
      step(); if_req_i = 0;
      chk("starve_grants", n_grants, 10);
      chk("starve_pattern", g_code, 32'hDDFD_DDDF);

      // Memory never answers: timeout.
      step();
      mem_lat = -1; e0 = err_cnt; c0 = ce_run;
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400; d_sel_i = 4'h1;
      wait_ack(1, 300, cyc);
      chk("tmo_busy_cycles", ce_run - c0, 255);
      chk("tmo_err_with_ack", err_o, 1);
      chk("tmo_data_zero", d_rdata_o, 0);
      chk("tmo_ce_low", m_ce_o, 0);
      step(); d_req_i = 0;
      @(negedge clk); #1;
      chk("tmo_err_once", err_cnt - e0, 1);
      chk("tmo_back_idle_ce", m_ce_o, 0);

      // Reset during BUSY_D with a late memory ack.
      step();
      d0 = dack_cnt;
      d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_sel_i = 4'hF;
      step();
      chk("rstb_busy", m_ce_o, 1);
      d_req_i = 0; rst = 1;
      step();
      rst = 0; force_data = 32'h1234_5678; force_ack = 1;
      chk("rstb_ce", m_ce_o, 0);
      chk("rstb_addr", m_addr_o, 0);
      chk("rstb_sel", m_sel_o, 0);
      chk("rstb_if_data", if_data_o, 0);
      step();
      force_ack = 0;
      chk("rstb_no_dack", d_ack_o, 0);
      chk("rstb_late_ack_ignored", d_rdata_o, 0);
      chk("rstb_ce_idle", m_ce_o, 0);
      step();
      chk("rstb_dack_count", dack_cnt - d0, 0);
      mem_lat = 1;
      if_req_i = 1; if_addr_i = 32'h140;
      wait_ack(0, 20, cyc);
      chk("rstb_fetch_latency", cyc, 4);
      chk("rstb_fetch_data", if_data_o, 32'h5A5A_0140);
      step(); if_req_i = 0;
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit reached: got running expected finished");
      $fatal(1);
   end
endmodule
